fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage between the PC/register-file core and decode.
- Consumes the core's current PC and drives the core's `pcread` advance strobe.
- Issues word reads to a fixed-latency instruction BRAM and buffers returned words in a small in-order FIFO.
- Presents {inst, inst_pc} to decode over a valid/ready handshake; a redirect (taken branch/jump, asserted in the same cycle as the core's `pcenable`) flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, ≥2. Full throughput requires DEPTH ≥ IMEM_LAT+2.
- IMEM_LAT, 1: BRAM read latency in cycles, 1..4.
- IMEM_AW, 14: instruction-memory word-address width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- pc  in  32  current PC from core
- pcread  out  1  request core to advance pc by 4 at this edge
- redirect  in  1  PC being reloaded this edge (mirrors core pcenable); flush
- imem_en  out  1  BRAM read enable
- imem_addr  out  IMEM_AW  BRAM word address
- imem_rdata  in  32  BRAM data, valid IMEM_LAT cycles after imem_en
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst

Behaviour:
- Reset: clk, rstn; reset is synchronous, active-low.
  - While rstn=0: pcread=0, imem_en=0, inst_valid=0, inst=0, inst_pc=0.
  - Also cleared: FIFO pointers/count and all in-flight valid bits.
  - A reset mid-operation drops everything; responses arriving after reset are ignored.
- Occupancy: occ = FIFO count + number of in-flight reads. Both terms are registered; there is no pop bypass.
- Issue condition: issue = rstn & ~redirect & (occ < DEPTH).
  - pcread = imem_en = issue, combinational.
  - imem_addr = pc[IMEM_AW+1:2], combinational.
  - pc[1:0] is ignored.
- In-flight tracking: an IMEM_LAT-stage shift register of {valid, pc}.
  - Stage 0 is loaded with {issue, pc} each edge.
  - When the last stage is valid, imem_rdata is paired with its pc and pushed into the FIFO at that edge.
- Latency: issue in cycle t gives data on imem_rdata in cycle t+IMEM_LAT and inst_valid=1 in cycle t+IMEM_LAT+1 (if the FIFO was empty).
- FIFO output (show-ahead):
  - inst_valid = ~empty.
  - inst and inst_pc are taken from the head entry, and forced to 0 when empty.
  - Pop on inst_valid & inst_ready.
- Simultaneous push and pop: count unchanged; ordering strictly preserved.
- Full FIFO: push cannot overflow, because occ < DEPTH is guaranteed at issue time.
- Redirect (highest priority after reset):
  - At that edge, FIFO count is set to 0 and all in-flight valid bits are cleared.
  - No issue in the redirect cycle.
  - The next cycle issues from the new pc.
  - A handshake that completes in the redirect cycle is still a transfer from the decode side; decode is responsible for discarding it.
- Back-to-back redirects: each one flushes; no issue occurs in any redirect cycle.
- PC wrap: 0xFFFFFFFC+4 wraps in the core. inst_pc is carried verbatim; no special handling.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs `perf_fetched` (32) and `perf_bubble` (32).
  - `perf_fetched` counts pops.
  - `perf_bubble` counts cycles with inst_valid=0 & inst_ready=1.
  - Both reset to 0, wrap modulo 2^32, and keep counting across redirects.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - XLEN=32 and INST_W=32.
  - typedef fetch_entry_t {logic[31:0] pc; logic[31:0] inst;}.
- Sub-module fetch_fifo:
  - Parameter DEPTH; synchronous, show-ahead.
  - Ports push/pop/flush/count/empty; carries fetch_entry_t.
- fetch_unit holds the issue logic, the in-flight shift register and the perf counters.

Test Plan:
- Reset and streaming. Stimulus: rstn=0 for 3 cycles with inst_ready=1, a core PC model starting at 0, and BRAM mem[i]=0xA000_0000+i. Required:
  - pcread/imem_en/inst_valid stay 0 during reset.
  - After release, issues go to addr 0,1,2,…
  - First inst_valid is 2 cycles after the first issue, with inst=0xA0000000 and inst_pc=0.
  - Thereafter one instruction per cycle.
- Backpressure. Stimulus: inst_ready=0 from start, DEPTH=4. Required:
  - Exactly 4 issues, then pcread=0.
  - Raising ready delivers inst_pc 0,4,8,12 in order, then issuing resumes; no loss or duplication.
- Redirect with in-flight reads. Stimulus: while streaming, redirect=1 for one cycle with core next_pc=0x100. Required:
  - pcread=0 in that cycle.
  - Pre-redirect responses are discarded.
  - The next delivered inst_pc is 0x100 with inst=mem[0x40].
- Redirect with full FIFO. Stimulus: inst_ready=0, FIFO full, redirect=1. Required: inst_valid=0 the next cycle, and a new issue in the cycle after the redirect.
- Latency sweep. Stimulus: IMEM_LAT=3, DEPTH=8. Required: first inst_valid 4 cycles after the first issue; steady-state 1 instruction per cycle with ready=1.
- Mid-operation reset and perf counters. Stimulus: rstn=0 for 1 cycle while the FIFO holds entries. Required:
  - All outputs return to 0.
  - Stale BRAM responses are never delivered.
  - With FETCH_PERF_CNT_EN, perf_fetched=10 after 10 handshakes.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Purpose  : Shared widths and the FIFO entry type for the fetch stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  // One buffered fetch: the instruction word paired with the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Purpose  : Small in-order show-ahead FIFO of fetch entries with a
//            single-cycle flush. Head entry is readable whenever not empty.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // The guards keep the pointers consistent even if a caller misbehaves.
  assign empty   = (count == '0);
  assign do_push = push & (count != FULL);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; entries carry no reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Issues word reads to a fixed-latency
//            BRAM while buffer space (FIFO plus in-flight reads) allows,
//            advances the core PC with pcread, and hands {inst, inst_pc} to
//            decode over valid/ready. A redirect flushes everything.
// Options  : FETCH_PERF_CNT_EN adds perf_fetched / perf_bubble counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IMEM_LAT = 1,
  parameter int IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [XLEN-1:0]    pc,
  output logic               pcread,
  input  logic               redirect,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INST_W-1:0]  inst,
  output logic [XLEN-1:0]    inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubble
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(DEPTH + IMEM_LAT + 1) + 1;
  localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

  logic [IMEM_LAT-1:0] fl_valid;
  logic [XLEN-1:0]     fl_pc [IMEM_LAT];
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  fetch_entry_t        fifo_head;
  fetch_entry_t        push_entry;
  logic [OW-1:0]       inflight;
  logic [OW-1:0]       occ;
  logic                issue;
  logic                push;
  logic                pop;

  // Number of reads still travelling through the BRAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      inflight = inflight + OW'(fl_valid[i]);
    end
  end

  // Reserve a FIFO slot for every in-flight read so a push can never overflow.
  assign occ       = OW'(fifo_count) + inflight;
  assign issue     = rstn & ~redirect & (occ < DEPTH_OCC);
  assign pcread    = issue;
  assign imem_en   = issue;
  assign imem_addr = pc[IMEM_AW+1:2];

  // In-flight valid bits; cleared by reset and redirect so late data is dropped.
  always_ff @(posedge clk) begin
    if (!rstn || redirect) begin
      fl_valid <= '0;
    end else begin
      fl_valid[0] <= issue;
      for (int i = 1; i < IMEM_LAT; i++) begin
        fl_valid[i] <= fl_valid[i-1];
      end
    end
  end

  // PC of each in-flight read travels alongside its valid bit.
  always_ff @(posedge clk) begin
    fl_pc[0] <= pc;
    for (int i = 1; i < IMEM_LAT; i++) begin
      fl_pc[i] <= fl_pc[i-1];
    end
  end

  assign push            = fl_valid[IMEM_LAT-1];
  assign push_entry.pc   = fl_pc[IMEM_LAT-1];
  assign push_entry.inst = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs are gated by rstn so they read zero for the whole reset cycle.
  assign inst_valid = rstn & ~fifo_empty;
  assign inst       = inst_valid ? fifo_head.inst : '0;
  assign inst_pc    = inst_valid ? fifo_head.pc   : '0;
  assign pop        = inst_valid & inst_ready;

`ifdef FETCH_PERF_CNT_EN
  // Delivered-instruction and starved-decode counters; unaffected by redirect.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_fetched <= '0;
      perf_bubble  <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (!inst_valid && inst_ready) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
